mmio_mem_controller: RTL

- Second-generation data-side memory controller between the core data port and the shared dual-port block RAM (port B) plus the MMIO page.
- Decodes the MMIO page and drives the display, LED and UART registers.
- Buffers UART traffic in parametrised TX/RX FIFOs with ready/valid handshakes and raises an interrupt line.
- All read data is returned with a uniform 1-cycle latency, matching the BRAM.

---
 rtl/mmio_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/mmio_mem_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the data-side memory controller.
//   - MMIO register offsets (mem_addr[11:0] within the MMIO page)
//   - bit positions inside the UART_STATUS word
//   - rd_src_t: which source answers a read one cycle after it is issued
package mmio_pkg;

  localparam logic [11:0] OFF_DISP_CTRL  = 12'h004;
  localparam logic [11:0] OFF_DISP_DAT   = 12'h008;
  localparam logic [11:0] OFF_LED        = 12'h00C;
  localparam logic [11:0] OFF_UART_DATA  = 12'h400;
  localparam logic [11:0] OFF_UART_STAT  = 12'h404;
  localparam logic [11:0] OFF_UART_IRQEN = 12'h408;

  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_OVF       = 2;
  localparam int ST_TX_EMPTY     = 3;
  localparam int ST_TX_DROP      = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_MMIO = 2'd1,
    SRC_NONE = 2'd2
  } rd_src_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, i_rst     clock, synchronous active-high reset (flushes pointers/count)
//   i_push, i_din  write request and data
//   i_pop          read request; ignored while empty
//   o_dout         head entry, forced to 0 while empty
//   o_full, o_empty, o_count  occupancy
// A push while full is accepted only if a pop happens in the same cycle;
// a simultaneous push and pop leaves the count unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is not reset; reading it is masked by o_empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_mem_controller.sv
// mmio_mem_controller: data-side controller between the core data port,
// BRAM port B and the MMIO page (display, LED, UART with TX/RX FIFOs).
// Ports:
//   clk, Rst                       clock, synchronous active-high reset
//   mem_wea/mem_rea/mem_en/mem_addr/mem_din   core request
//   mem_dout                       read data, 1 cycle after mem_rea, held otherwise
//   bram_enb/web/addrb/dinb/doutb  BRAM port B (1-cycle read latency)
//   uart_tx_data/valid/ready       TX stream out of the TX FIFO
//   uart_rx_data/valid             RX byte pulse into the RX FIFO
//   disp_wea, disp_dat, led        MMIO output registers
//   irq                            registered UART interrupt level
// Handshake: the TX stream is valid/ready; a byte transfers on every cycle
// where uart_tx_valid & uart_tx_ready, valid never depends on ready, and the
// head byte stays stable until it transfers. RX has no back-pressure.
module mmio_mem_controller
  import mmio_pkg::*;
#(
  parameter logic [19:0] MMIO_PAGE = 20'haaaaa,
  parameter int          MEM_AW    = 11,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter int          LED_W     = 16
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              mem_wea,
  input  logic              mem_rea,
  input  logic [3:0]        mem_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_din,
  output logic [31:0]       mem_dout,
  output logic              bram_enb,
  output logic [3:0]        bram_web,
  output logic [MEM_AW-1:0] bram_addrb,
  output logic [31:0]       bram_dinb,
  input  logic [31:0]       bram_doutb,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              disp_wea,
  output logic [31:0]       disp_dat,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  // Address decode
  logic [19:0] w_page;
  logic [11:0] w_off;
  logic        w_is_ram;
  logic        w_is_mmio;
  logic        w_mmio_wr;
  logic        w_mmio_rd;

  assign w_page    = mem_addr[31:12];
  assign w_off     = mem_addr[11:0];
  assign w_is_ram  = (w_page < MMIO_PAGE);
  assign w_is_mmio = (w_page == MMIO_PAGE);
  assign w_mmio_wr = mem_wea & w_is_mmio;
  assign w_mmio_rd = mem_rea & w_is_mmio;

  assign bram_enb   = (mem_wea | mem_rea) & w_is_ram;
  assign bram_web   = (mem_wea & w_is_ram) ? mem_en : 4'b0000;
  assign bram_addrb = mem_addr[MEM_AW+1:2];
  assign bram_dinb  = mem_din;

  // MMIO registers
  logic             r_disp_wea;
  logic [31:0]      r_disp_dat;
  logic [LED_W-1:0] r_led;
  logic [1:0]       r_irqen;
  logic             r_rx_ovf;
  logic             r_tx_drop;
  logic             r_irq;

  assign disp_wea = r_disp_wea;
  assign disp_dat = r_disp_dat;
  assign led      = r_led;
  assign irq      = r_irq;

  // FIFOs
  logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [TX_CW-1:0] w_tx_count;
  logic             w_rx_pop, w_rx_full, w_rx_empty;
  logic [RX_CW-1:0] w_rx_count;
  logic [7:0]       w_rx_head;

  assign w_tx_push     = w_mmio_wr & (w_off == OFF_UART_DATA);
  assign uart_tx_valid = ~w_tx_empty;
  assign w_tx_pop      = uart_tx_valid & uart_tx_ready;
  assign w_rx_pop      = w_mmio_rd & (w_off == OFF_UART_DATA) & ~w_rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .i_rst   (Rst),
    .i_push  (w_tx_push),
    .i_din   (mem_din[7:0]),
    .i_pop   (w_tx_pop),
    .o_dout  (uart_tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .i_rst   (Rst),
    .i_push  (uart_rx_valid),
    .i_din   (uart_rx_data),
    .i_pop   (w_rx_pop),
    .o_dout  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // Status word and MMIO read mux, both from pre-write state
  logic [31:0] w_status;
  logic [31:0] w_mmio_rdata;

  always_comb begin
    w_status = '0;
    w_status[ST_RX_NONEMPTY] = ~w_rx_empty;
    w_status[ST_TX_FULL]     = w_tx_full;
    w_status[ST_RX_OVF]      = r_rx_ovf;
    w_status[ST_TX_EMPTY]    = w_tx_empty;
    w_status[ST_TX_DROP]     = r_tx_drop;
    w_status[ST_RX_COUNT_LSB +: 8] = 8'(w_rx_count);
    w_status[ST_TX_COUNT_LSB +: 8] = 8'(w_tx_count);
  end

  always_comb begin
    w_mmio_rdata = '0;
    if (w_is_mmio) begin
      case (w_off)
        OFF_DISP_CTRL:  w_mmio_rdata = {31'b0, r_disp_wea};
        OFF_DISP_DAT:   w_mmio_rdata = r_disp_dat;
        OFF_LED:        w_mmio_rdata = 32'(r_led);
        OFF_UART_DATA:  w_mmio_rdata = {24'b0, w_rx_head};
        OFF_UART_STAT:  w_mmio_rdata = w_status;
        OFF_UART_IRQEN: w_mmio_rdata = {30'b0, r_irqen};
        default:        w_mmio_rdata = '0;
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as a W1C wins.
  logic w_stat_wr;
  logic w_rx_ovf_set;
  logic w_tx_drop_set;

  assign w_stat_wr     = w_mmio_wr & (w_off == OFF_UART_STAT);
  assign w_rx_ovf_set  = uart_rx_valid & w_rx_full & ~w_rx_pop;
  assign w_tx_drop_set = w_tx_push & w_tx_full & ~w_tx_pop;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_disp_wea <= 1'b0;
      r_disp_dat <= '0;
      r_led      <= '0;
      r_irqen    <= '0;
      r_rx_ovf   <= 1'b0;
      r_tx_drop  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_mmio_wr) begin
        case (w_off)
          OFF_DISP_CTRL:  r_disp_wea <= mem_din[0];
          OFF_DISP_DAT:   r_disp_dat <= mem_din;
          OFF_LED:        r_led      <= mem_din[LED_W-1:0];
          OFF_UART_IRQEN: r_irqen    <= mem_din[1:0];
          default:        ;
        endcase
      end
      r_rx_ovf  <= (r_rx_ovf  & ~(w_stat_wr & mem_din[ST_RX_OVF]))  | w_rx_ovf_set;
      r_tx_drop <= (r_tx_drop & ~(w_stat_wr & mem_din[ST_TX_DROP])) | w_tx_drop_set;
      r_irq     <= (r_irqen[0] & ~w_rx_empty) | (r_irqen[1] & w_tx_empty);
    end
  end

  // Read pipeline: source and MMIO value captured with the request; the
  // delivered word is latched so mem_dout holds while no read is in flight.
  rd_src_t     r_src;
  logic        r_rd_pend;
  logic [31:0] r_mmio_rdata;
  logic [31:0] r_last;
  logic [31:0] w_rd_mux;

  always_comb begin
    case (r_src)
      SRC_RAM:  w_rd_mux = bram_doutb;
      SRC_MMIO: w_rd_mux = r_mmio_rdata;
      default:  w_rd_mux = '0;
    endcase
  end

  assign mem_dout = r_rd_pend ? w_rd_mux : r_last;

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_src        <= SRC_RAM;
      r_rd_pend    <= 1'b0;
      r_mmio_rdata <= '0;
      r_last       <= '0;
    end else begin
      r_rd_pend <= mem_rea;
      if (mem_rea) begin
        r_src        <= w_is_ram ? SRC_RAM : (w_is_mmio ? SRC_MMIO : SRC_NONE);
        r_mmio_rdata <= w_mmio_rdata;
      end
      if (r_rd_pend) r_last <= w_rd_mux;
    end
  end

endmodule
